// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 2;

   // High-phase length for divisor n; odd divisors get the extra cycle high.
   function automatic logic [31:0] high_len(input logic [31:0] n);
      return (n + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle between a divider client and clk_div_prog.
interface clk_div_prog_if #(
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic [CNT_W-1:0] div_val;
   logic             div_load;
   logic             clk_out;
   logic             tick;
   logic [CNT_W-1:0] div_cur;
   logic             pend;
   logic             err;
   logic             running;

   modport master (
      output en, div_val, div_load,
      input  clk_out, tick, div_cur, pend, err, running
   );

   modport slave (
      input  en, div_val, div_load,
      output clk_out, tick, div_cur, pend, err, running
   );
endinterface

// File: rtl/clk_div_cnt.sv
// Wrapping period counter: terminal-count flag and high-phase compare of the next count.
module clk_div_cnt
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic [CNT_W-1:0] i_n,
   input  logic [CNT_W-1:0] i_n_nxt,
   output logic             o_tc,
   output logic             o_hi_nxt
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign o_tc = i_run && (r_cnt == i_n - ONE);

   always_comb begin
      w_cnt_nxt = '0;
      if (i_run && !o_tc) begin
         w_cnt_nxt = r_cnt + ONE;
      end
   end

   // Compared against the divisor of the period the next count belongs to.
   assign o_hi_nxt = 32'(w_cnt_nxt) < high_len(32'(i_n_nxt));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run/drain FSM, shadowed divisor load, registered outputs.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned DEFAULT_DIV = 8
) (
   input  logic           clk,
   input  logic           rst,
   clk_div_prog_if.slave  bus
);

   localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_clk_out;
   logic             r_tick;
   logic             r_err;
   logic             r_pend;
   logic [CNT_W-1:0] r_div_cur;
   logic [CNT_W-1:0] r_shadow;

   logic             w_tc;
   logic             w_hi_nxt;
   logic             w_bound;
   logic             w_load_ok;
   logic             w_tick_nxt;
   logic             w_out_nxt;
   logic [CNT_W-1:0] w_div_nxt;

   clk_div_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_run    (r_state != IDLE),
      .i_n      (r_div_cur),
      .i_n_nxt  (w_div_nxt),
      .o_tc     (w_tc),
      .o_hi_nxt (w_hi_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A RUN period ending with en low goes straight to IDLE; it is already at its boundary.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.en) w_state_nxt = RUN;
         RUN: begin
            if (w_tc)         w_state_nxt = bus.en ? RUN : IDLE;
            else if (!bus.en) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (bus.en)       w_state_nxt = RUN;
            else if (w_tc)    w_state_nxt = IDLE;
         end
         default:             w_state_nxt = IDLE;
      endcase
      w_bound    = (r_state == IDLE) || w_tc;
      w_tick_nxt = w_bound && (w_state_nxt == RUN);
      w_load_ok  = bus.div_load && (32'(bus.div_val) >= MIN_DIV);
   end

   always_comb begin
      w_div_nxt = r_div_cur;
      if (w_bound) begin
         w_div_nxt = w_load_ok ? bus.div_val : r_shadow;
      end
   end

   assign w_out_nxt = w_hi_nxt && (w_state_nxt != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
         r_err     <= 1'b0;
         r_pend    <= 1'b0;
         r_div_cur <= DEF_N;
         r_shadow  <= DEF_N;
      end else begin
         r_clk_out <= w_out_nxt;
         r_tick    <= w_tick_nxt;
         r_err     <= bus.div_load && !w_load_ok;
         r_div_cur <= w_div_nxt;
         if (w_load_ok) begin
            r_shadow <= bus.div_val;
         end
         if (w_bound) begin
            r_pend <= 1'b0;
         end else if (w_load_ok) begin
            r_pend <= 1'b1;
         end
      end
   end

   assign bus.clk_out = r_clk_out;
   assign bus.tick    = r_tick;
   assign bus.err     = r_err;
   assign bus.pend    = r_pend;
   assign bus.div_cur = r_div_cur;
   assign bus.running = (r_state != IDLE);

endmodule
